// File: rtl/fu_issue_pkg.sv
// fu_issue_pkg: shared widths, reservation-station entry type and wakeup match for fu_issue_rs
package fu_issue_pkg;
  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int DEPTH = 4;
  localparam int IDX_BITS = $clog2(DEPTH);
  typedef logic [PRN_BITS-1:0] prn_arr_t [MAX_OPERANDS];
  typedef logic flag_arr_t [MAX_OPERANDS];
  typedef struct packed {
    logic valid;
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_prn;
    logic [MAX_OPERANDS-1:0] src_rdy;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
  } rs_entry_t;
  function automatic logic wake_match(input logic wb_valid, input flag_arr_t wb_data_valid,
                                      input prn_arr_t wb_prn, input logic [PRN_BITS-1:0] prn);
    wake_match = 1'b0;
    for (int j = 0; j < MAX_OPERANDS; j++)
      wake_match |= wb_valid && wb_data_valid[j] && (wb_prn[j] == prn);
  endfunction
endpackage

// File: rtl/fu_issue_rs_select.sv
// rs_select_lowest: DEPTH-wide priority encoder granting the lowest-index request
module rs_select_lowest
  import fu_issue_pkg::*;
(
  input  logic [DEPTH-1:0]    req,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) idx = req[i] ? IDX_BITS'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/fu_issue_rs.sv
// fu_issue_rs: per-FU reservation station with wakeup, lowest-index select and registered issue; FU_ISSUE_RS_BYPASS_EN enables same-cycle broadcast bypass
module fu_issue_rs
  import fu_issue_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [INST_ID_BITS-1:0] disp_inst_id,
  input  logic [31:0]             disp_inst,
  input  logic [63:0]             disp_pc,
  input  logic [PRN_BITS-1:0]     disp_src_prn [MAX_OPERANDS],
  input  logic                    disp_src_rdy [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     disp_out_prn [MAX_OPERANDS],
  input  logic                    wb_valid,
  input  logic [PRN_BITS-1:0]     wb_prn [MAX_OPERANDS],
  input  logic                    wb_data_valid [MAX_OPERANDS],
  input  logic [63:0]             wb_data [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prf_rd_prn [MAX_OPERANDS],
  input  logic [63:0]             prf_rd_data [MAX_OPERANDS],
  output logic [INST_ID_BITS-1:0] inst_id,
  output logic [31:0]             inst,
  output logic [63:0]             op [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     out_prn [MAX_OPERANDS],
  output logic [63:0]             pc,
  output logic                    inst_valid
);
  rs_entry_t rs [DEPTH];
  rs_entry_t disp_entry;
  logic [DEPTH-1:0] vld, rdy;
  logic [DEPTH-1:0][MAX_OPERANDS-1:0] wake;
  logic [IDX_BITS-1:0] free_idx, sel_idx;
  logic sel_v;
  logic [63:0] op_next [MAX_OPERANDS];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = rs[i].valid;
      for (int k = 0; k < MAX_OPERANDS; k++)
        wake[i][k] = wake_match(wb_valid, wb_data_valid, wb_prn, rs[i].src_prn[k]);
`ifdef FU_ISSUE_RS_BYPASS_EN
      rdy[i] = rs[i].valid && &(rs[i].src_rdy | wake[i]);
`else
      rdy[i] = rs[i].valid && &rs[i].src_rdy;
`endif
    end
  end
  rs_select_lowest u_free (.req(~vld), .idx(free_idx), .valid(disp_ready));
  rs_select_lowest u_sel (.req(rdy), .idx(sel_idx), .valid(sel_v));
  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) prf_rd_prn[k] = sel_v ? rs[sel_idx].src_prn[k] : '0;
  end
`ifdef FU_ISSUE_RS_BYPASS_EN
  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      op_next[k] = prf_rd_data[k];
      for (int j = 0; j < MAX_OPERANDS; j++)
        op_next[k] = (wb_valid && wb_data_valid[j] && wb_prn[j] == prf_rd_prn[k]) ? wb_data[j] : op_next[k];
    end
  end
`else
  logic unused_wb;
  always_comb begin
    unused_wb = 1'b0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      op_next[k] = prf_rd_data[k];
      unused_wb ^= ^wb_data[k];
    end
  end
`endif
  always_comb begin
    disp_entry = '0;
    disp_entry.valid = 1'b1;
    disp_entry.inst_id = disp_inst_id;
    disp_entry.inst = disp_inst;
    disp_entry.pc = disp_pc;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      disp_entry.src_prn[k] = disp_src_prn[k];
      disp_entry.src_rdy[k] = disp_src_rdy[k] | wake_match(wb_valid, wb_data_valid, wb_prn, disp_src_prn[k]);
      disp_entry.out_prn[k] = disp_out_prn[k];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rs[i] <= '0;
      inst_valid <= 1'b0;
      inst_id <= '0;
      inst <= '0;
      pc <= '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        op[k] <= '0;
        out_prn[k] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) rs[i].valid <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) rs[i].src_rdy <= rs[i].src_rdy | wake[i];
      inst_valid <= sel_v;
      if (sel_v) begin
        rs[sel_idx].valid <= 1'b0;
        inst_id <= rs[sel_idx].inst_id;
        inst <= rs[sel_idx].inst;
        pc <= rs[sel_idx].pc;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          op[k] <= op_next[k];
          out_prn[k] <= rs[sel_idx].out_prn[k];
        end
      end
      if (disp_valid && disp_ready) rs[free_idx] <= disp_entry;
    end
  end
endmodule

// File: tb/tb_fu_issue_rs.sv
// tb_fu_issue_rs: directed stimulus with a scoreboard queue checked by an issue monitor
module tb_fu_issue_rs;
  import fu_issue_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready, wb_valid, inst_valid;
  logic [INST_ID_BITS-1:0] disp_inst_id, inst_id;
  logic [31:0] disp_inst, inst;
  logic [63:0] disp_pc, pc;
  logic [PRN_BITS-1:0] disp_src_prn [MAX_OPERANDS];
  logic disp_src_rdy [MAX_OPERANDS];
  logic [PRN_BITS-1:0] disp_out_prn [MAX_OPERANDS];
  logic [PRN_BITS-1:0] wb_prn [MAX_OPERANDS];
  logic wb_data_valid [MAX_OPERANDS];
  logic [63:0] wb_data [MAX_OPERANDS];
  logic [PRN_BITS-1:0] prf_rd_prn [MAX_OPERANDS];
  logic [63:0] prf_rd_data [MAX_OPERANDS];
  logic [63:0] op [MAX_OPERANDS];
  logic [PRN_BITS-1:0] out_prn [MAX_OPERANDS];
`ifdef FU_ISSUE_RS_BYPASS_EN
  localparam int WLAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int WLAT = 2;
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    int id;
    logic [63:0] op0, op1, op2;
    logic [PRN_BITS-1:0] out0;
    logic [63:0] pc;
    logic [31:0] inst;
    int at;
  } exp_t;
  exp_t sb [$];
  int tests = 0, fails = 0, cyc = 0;

  fu_issue_rs dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst_id(disp_inst_id), .disp_inst(disp_inst), .disp_pc(disp_pc),
    .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy), .disp_out_prn(disp_out_prn),
    .wb_valid(wb_valid), .wb_prn(wb_prn), .wb_data_valid(wb_data_valid), .wb_data(wb_data),
    .prf_rd_prn(prf_rd_prn), .prf_rd_data(prf_rd_data), .inst_id(inst_id), .inst(inst),
    .op(op), .out_prn(out_prn), .pc(pc), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pd(input logic [PRN_BITS-1:0] p);
    return {8'hAB, 50'h0, p};
  endfunction
  function automatic logic [63:0] wd(input logic [PRN_BITS-1:0] p);
    return {8'hCD, 50'h0, p};
  endfunction

  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      prf_rd_data[k] = pd(prf_rd_prn[k]);
      wb_data[k] = wd(wb_prn[k]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch_set(input int id, input logic [PRN_BITS-1:0] s0, s1, s2,
                              input logic r0, r1, r2, input logic [PRN_BITS-1:0] o0);
    disp_valid = 1'b1;
    disp_inst_id = INST_ID_BITS'(id);
    disp_inst = 32'h1000_0000 + 32'(id);
    disp_pc = 64'h8000 + 64'(id * 4);
    disp_src_prn[0] = s0; disp_src_prn[1] = s1; disp_src_prn[2] = s2;
    disp_src_rdy[0] = r0; disp_src_rdy[1] = r1; disp_src_rdy[2] = r2;
    disp_out_prn[0] = o0; disp_out_prn[1] = '0; disp_out_prn[2] = '0;
  endtask

  task automatic exp_issue(input int id, input logic [PRN_BITS-1:0] s1, s2, o0, input int at,
                           input logic [63:0] op0);
    exp_t e;
    e.id = id; e.op0 = op0; e.op1 = pd(s1); e.op2 = pd(s2); e.out0 = o0;
    e.pc = 64'h8000 + 64'(id * 4); e.inst = 32'h1000_0000 + 32'(id); e.at = at;
    sb.push_back(e);
  endtask

  task automatic wb_clear();
    wb_valid = 1'b0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      wb_prn[k] = '0;
      wb_data_valid[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got inst_id=%0d at cycle %0d, required no issue", inst_id, cyc);
      end else begin
        e = sb.pop_front();
        chk("issue_id", 64'(inst_id), 64'(e.id));
        chk("issue_cycle", 64'(cyc), 64'(e.at));
        chk("issue_op0", op[0], e.op0);
        chk("issue_op1", op[1], e.op1);
        chk("issue_op2", op[2], e.op2);
        chk("issue_out_prn0", 64'(out_prn[0]), 64'(e.out0));
        chk("issue_pc", pc, e.pc);
        chk("issue_inst", 64'(inst), 64'(e.inst));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, b;
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
    dispatch_set(0, 0, 0, 0, 1, 1, 1, 0);
    disp_valid = 1'b0;
    wb_clear();
    repeat (2) step();
    rst = 1'b0;
    chk("rst_inst_valid", 64'(inst_valid), 0);
    chk("rst_inst_id", 64'(inst_id), 0);
    chk("rst_inst", 64'(inst), 0);
    chk("rst_pc", pc, 0);
    chk("rst_op0", op[0], 0);
    chk("rst_out_prn0", 64'(out_prn[0]), 0);
    chk("rst_disp_ready", 64'(disp_ready), 1);
    chk("rst_prf_rd_prn0", 64'(prf_rd_prn[0]), 0);

    c = cyc;
    dispatch_set(5, 10, 11, 0, 1, 1, 1, 20);
    exp_issue(5, 11, 0, 20, c + 2, pd(10));
    step();
    disp_valid = 1'b0;
    chk("t1_prf_rd_prn0", 64'(prf_rd_prn[0]), 10);
    step();
    step();
    chk("t1_idle_after_issue", 64'(inst_valid), 0);

    dispatch_set(1, 9, 0, 0, 0, 1, 1, 21);
    step();
    disp_valid = 1'b0;
    repeat (3) begin
      step();
      chk("t2_wait_not_ready", 64'(inst_valid), 0);
    end
    b = cyc;
    wb_valid = 1'b1; wb_prn[0] = 9; wb_data_valid[0] = 1'b1;
    exp_issue(1, 0, 0, 21, b + WLAT, BYP ? wd(9) : pd(9));
    step();
    wb_clear();
    repeat (2) step();

    for (int i = 0; i < 4; i++) begin
      dispatch_set(10 + i, PRN_BITS'(30 + i), 0, 0, 0, 1, 1, PRN_BITS'(22 + i));
      step();
    end
    disp_valid = 1'b0;
    chk("t3_full_ready_low", 64'(disp_ready), 0);
    b = cyc;
    wb_valid = 1'b1; wb_prn[0] = 32; wb_data_valid[0] = 1'b1;
    exp_issue(12, 0, 0, 24, b + WLAT, BYP ? wd(32) : pd(32));
    chk("t3_full_during_wake", 64'(disp_ready), 0);
    step();
    wb_clear();
    repeat (WLAT - 1) begin
      chk("t3_full_before_issue", 64'(disp_ready), 0);
      step();
    end
    chk("t3_ready_after_issue", 64'(disp_ready), 1);

    dispatch_set(40, 1, 2, 3, 1, 1, 1, 40);
    flush = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    chk("flush_inst_valid", 64'(inst_valid), 0);
    chk("flush_disp_ready", 64'(disp_ready), 1);
    wb_valid = 1'b1;
    wb_prn[0] = 30; wb_prn[1] = 31; wb_prn[2] = 33;
    for (int k = 0; k < MAX_OPERANDS; k++) wb_data_valid[k] = 1'b1;
    step();
    wb_clear();
    chk("flush_no_select", 64'(prf_rd_prn[0]), 0);
    repeat (4) step();

    for (int i = 0; i < 4; i++) begin
      dispatch_set(50 + i, PRN_BITS'(40 + i), 0, 0, 0, 1, 1, PRN_BITS'(50 + i));
      step();
    end
    disp_valid = 1'b0;
    b = cyc;
    wb_valid = 1'b1;
    wb_prn[0] = 40; wb_data_valid[0] = 1'b1;
    wb_prn[1] = 43; wb_data_valid[1] = 1'b1;
    exp_issue(50, 0, 0, 50, b + WLAT, BYP ? wd(40) : pd(40));
    exp_issue(53, 0, 0, 53, b + WLAT + 1, pd(43));
    step();
    wb_clear();
    repeat (3) step();
    b = cyc;
    wb_valid = 1'b1;
    wb_prn[0] = 41; wb_data_valid[0] = 1'b1;
    wb_prn[1] = 42; wb_data_valid[1] = 1'b1;
    exp_issue(51, 0, 0, 51, b + WLAT, BYP ? wd(41) : pd(41));
    exp_issue(52, 0, 0, 52, b + WLAT + 1, pd(42));
    step();
    wb_clear();
    repeat (3) step();

    c = cyc;
    dispatch_set(60, 45, 0, 0, 0, 1, 1, 61);
    wb_valid = 1'b1; wb_prn[2] = 45; wb_data_valid[2] = 1'b1;
    exp_issue(60, 0, 0, 61, c + 2, pd(45));
    step();
    disp_valid = 1'b0;
    wb_clear();
    repeat (4) step();

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_issues: got %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
